// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pattern select input and registered VGA output bundle
interface vga_pattern_gen_if #(
  parameter int PIX_SZ = 4,
  parameter int HSZ    = 10,
  parameter int VSZ    = 10
);
  logic [1:0]        mode_i;
  logic [PIX_SZ-1:0] o_r;
  logic [PIX_SZ-1:0] o_g;
  logic [PIX_SZ-1:0] o_b;
  logic              o_hsync;
  logic              o_vsync;
  logic              o_de;
  logic              o_frame_start;
  logic [HSZ-1:0]    hcount_o;
  logic [VSZ-1:0]    vcount_o;

  modport master (
    input  mode_i,
    output o_r, o_g, o_b, o_hsync, o_vsync, o_de, o_frame_start, hcount_o, vcount_o
  );

  modport slave (
    output mode_i,
    input  o_r, o_g, o_b, o_hsync, o_vsync, o_de, o_frame_start, hcount_o, vcount_o
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA timing, sync and test-pattern engine; VGA_PAT_SCROLL_EN adds per-frame scroll
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIX_SZ     = 4,
  parameter int BAR_W      = 80,
  parameter int CHK_LOG2   = 5,
  parameter int GRAD_SHIFT = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  vga_pattern_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSZ     = $clog2(H_TOTAL);
  localparam int VSZ     = $clog2(V_TOTAL);

  localparam logic [HSZ-1:0] H_LAST     = HSZ'(H_TOTAL - 1);
  localparam logic [HSZ-1:0] H_ACT      = HSZ'(H_ACTIVE);
  localparam logic [HSZ-1:0] H_ACT_LAST = HSZ'(H_ACTIVE - 1);
  localparam logic [HSZ-1:0] HS_START   = HSZ'(H_ACTIVE + H_FP);
  localparam logic [HSZ-1:0] HS_END     = HSZ'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VSZ-1:0] V_LAST     = VSZ'(V_TOTAL - 1);
  localparam logic [VSZ-1:0] V_ACT      = VSZ'(V_ACTIVE);
  localparam logic [VSZ-1:0] V_ACT_LAST = VSZ'(V_ACTIVE - 1);
  localparam logic [VSZ-1:0] VS_START   = VSZ'(V_ACTIVE + V_FP);
  localparam logic [VSZ-1:0] VS_END     = VSZ'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HSZ-1:0] BAR_W_C    = HSZ'(BAR_W);
  localparam logic           HS_ON      = 1'(HSYNC_POL);
  localparam logic           VS_ON      = 1'(VSYNC_POL);
  localparam logic [PIX_SZ-1:0] FULL    = '1;

  logic [HSZ-1:0]    h;
  logic [VSZ-1:0]    v;
  logic [1:0]        mode_q;
  logic [1:0]        mode_cur;
  logic              frame_first;
  logic              de;
  logic              hs_act;
  logic              vs_act;
  logic              chk;
  logic              border;
  logic [HSZ-1:0]    px;
  logic [HSZ-1:0]    bar_idx;
  logic [2:0]        idx;
  logic [PIX_SZ-1:0] lvl;
  logic [PIX_SZ-1:0] r_n;
  logic [PIX_SZ-1:0] g_n;
  logic [PIX_SZ-1:0] b_n;

`ifdef VGA_PAT_SCROLL_EN
  logic [HSZ-1:0] scroll;
  logic [HSZ:0]   px_sum;

  // Advancing on the last pixel means the new offset is live from the frame's first pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scroll <= '0;
    end else if (h == H_LAST && v == V_LAST) begin
      scroll <= (scroll == H_ACT_LAST) ? '0 : scroll + 1'b1;
    end
  end

  always_comb begin
    px_sum = {1'b0, h} + {1'b0, scroll};
    if (px_sum >= {1'b0, H_ACT}) px_sum = px_sum - {1'b0, H_ACT};
    px = px_sum[HSZ-1:0];
  end
`else
  assign px = h;
`endif

  always_comb begin
    frame_first = (h == '0) && (v == '0);
    // The first pixel of a frame already uses the mode being latched on that edge.
    mode_cur    = frame_first ? vif.mode_i : mode_q;
    de          = (h < H_ACT) && (v < V_ACT);
    hs_act      = (h >= HS_START) && (h < HS_END);
    vs_act      = (v >= VS_START) && (v < VS_END);
    bar_idx     = px / BAR_W_C;
    idx         = (bar_idx > HSZ'(7)) ? 3'd7 : bar_idx[2:0];
    chk         = px[CHK_LOG2] ^ v[CHK_LOG2];
    lvl         = PIX_SZ'(px >> GRAD_SHIFT);
    border      = (h == '0) || (h == H_ACT_LAST) || (v == '0) || (v == V_ACT_LAST);
    r_n         = '0;
    g_n         = '0;
    b_n         = '0;
    case (mode_cur)
      2'd0: begin
        r_n = {PIX_SZ{~idx[1]}};
        g_n = {PIX_SZ{~idx[2]}};
        b_n = {PIX_SZ{~idx[0]}};
      end
      2'd1: begin
        r_n = chk ? FULL : '0;
        g_n = chk ? FULL : '0;
        b_n = chk ? FULL : '0;
      end
      2'd2: begin
        r_n = lvl;
        g_n = lvl;
        b_n = lvl;
      end
      default: begin
        r_n = border ? FULL : '0;
        g_n = border ? FULL : '0;
        b_n = border ? FULL : '0;
      end
    endcase
    if (!de) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h                 <= '0;
      v                 <= '0;
      mode_q            <= '0;
      vif.o_r           <= '0;
      vif.o_g           <= '0;
      vif.o_b           <= '0;
      vif.o_hsync       <= ~HS_ON;
      vif.o_vsync       <= ~VS_ON;
      vif.o_de          <= 1'b0;
      vif.o_frame_start <= 1'b0;
      vif.hcount_o      <= '0;
      vif.vcount_o      <= '0;
    end else begin
      if (frame_first) mode_q <= vif.mode_i;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      vif.o_r           <= r_n;
      vif.o_g           <= g_n;
      vif.o_b           <= b_n;
      vif.o_hsync       <= hs_act ? HS_ON : ~HS_ON;
      vif.o_vsync       <= vs_act ? VS_ON : ~VS_ON;
      vif.o_de          <= de;
      vif.o_frame_start <= frame_first;
      vif.hcount_o      <= h;
      vif.vcount_o      <= v;
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed bench for vga_pattern_gen on a reduced 80x56 timing
module tb_vga_pattern_gen;
  localparam int H_ACTIVE   = 64;
  localparam int H_FP       = 4;
  localparam int H_SYNC     = 8;
  localparam int H_BP       = 4;
  localparam int V_ACTIVE   = 48;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 4;
  localparam int PIX_SZ     = 4;
  localparam int BAR_W      = 7;
  localparam int CHK_LOG2   = 3;
  localparam int GRAD_SHIFT = 1;
  localparam int H_TOTAL    = 80;
  localparam int V_TOTAL    = 56;
  localparam int FRAME      = H_TOTAL * V_TOTAL;
  localparam int HSZ        = $clog2(H_TOTAL);
  localparam int VSZ        = $clog2(V_TOTAL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pix = -1;
  int   last_fs = -1;

  vga_pattern_gen_if #(.PIX_SZ(PIX_SZ), .HSZ(HSZ), .VSZ(VSZ)) vif ();

  vga_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(0), .VSYNC_POL(0), .PIX_SZ(PIX_SZ), .BAR_W(BAR_W),
    .CHK_LOG2(CHK_LOG2), .GRAD_SHIFT(GRAD_SHIFT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [31:0] exp);
    check(tag, 32'({vif.o_r, vif.o_g, vif.o_b}), exp);
  endtask

  task automatic step();
    @(posedge clk);
    pix++;
    @(negedge clk);
    if (vif.o_frame_start) begin
      if (last_fs >= 0) check("fs_spacing", 32'(pix - last_fs), 32'(FRAME));
      last_fs = pix;
    end
  endtask

  task automatic at(input int f, input int vv, input int hh);
    int tgt;
    tgt = f * FRAME + vv * H_TOTAL + hh;
    while (pix < tgt) step();
    check("hcount", 32'(vif.hcount_o), 32'(hh));
    check("vcount", 32'(vif.vcount_o), 32'(vv));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_rgb({tag, "_rgb"}, 32'h000);
    check({tag, "_de"}, 32'(vif.o_de), 32'd0);
    check({tag, "_hs"}, 32'(vif.o_hsync), 32'd1);
    check({tag, "_vs"}, 32'(vif.o_vsync), 32'd1);
    check({tag, "_fs"}, 32'(vif.o_frame_start), 32'd0);
    check({tag, "_hc"}, 32'(vif.hcount_o), 32'd0);
    check({tag, "_vc"}, 32'(vif.vcount_o), 32'd0);
  endtask

  initial begin
    vif.mode_i = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst0");
    rst = 1'b0;

    // frame 0: colour bars, including the clamped region past 8*BAR_W
    at(0, 0, 0);   chk_rgb("bar_white", 32'hFFF); check("fs0", 32'(vif.o_frame_start), 32'd1);
    at(0, 0, 1);   check("fs_low", 32'(vif.o_frame_start), 32'd0);
    at(0, 0, 7);   chk_rgb("bar_yellow", 32'hFF0);
    at(0, 0, 14);  chk_rgb("bar_cyan", 32'h0FF);
    at(0, 0, 21);  chk_rgb("bar_green", 32'h0F0);
    at(0, 0, 28);  chk_rgb("bar_magenta", 32'hF0F);
    at(0, 0, 35);  chk_rgb("bar_red", 32'hF00);
    at(0, 0, 42);  chk_rgb("bar_blue", 32'h00F);
    at(0, 0, 49);  chk_rgb("bar_black", 32'h000);
    at(0, 0, 56);  chk_rgb("bar_clamp", 32'h000);
    at(0, 0, 63);  chk_rgb("bar_last", 32'h000); check("de_last", 32'(vif.o_de), 32'd1);
    at(0, 0, 64);  check("de_fp", 32'(vif.o_de), 32'd0); chk_rgb("blank_rgb", 32'h000);
    at(0, 0, 67);  check("hs_pre", 32'(vif.o_hsync), 32'd1);
    at(0, 0, 68);  check("hs_on", 32'(vif.o_hsync), 32'd0);
    at(0, 0, 75);  check("hs_end", 32'(vif.o_hsync), 32'd0);
    at(0, 0, 76);  check("hs_post", 32'(vif.o_hsync), 32'd1);

    at(0, 10, 0);  vif.mode_i = 2'd1;
    at(0, 10, 7);  chk_rgb("midframe_bars", 32'hFF0);
    at(0, 49, 0);  check("vs_pre", 32'(vif.o_vsync), 32'd1);
    at(0, 50, 0);  check("vs_on", 32'(vif.o_vsync), 32'd0); check("de_vfp", 32'(vif.o_de), 32'd0);
    at(0, 51, 79); check("vs_end", 32'(vif.o_vsync), 32'd0);
    at(0, 52, 0);  check("vs_post", 32'(vif.o_vsync), 32'd1);

    // frame 1: checkerboard
    at(1, 0, 0);   chk_rgb("chk_00", 32'h000); check("fs1", 32'(vif.o_frame_start), 32'd1);
    at(1, 0, 8);   chk_rgb("chk_80", 32'hFFF);
    at(1, 8, 0);   chk_rgb("chk_08", 32'hFFF);
    at(1, 8, 8);   chk_rgb("chk_88", 32'h000);
    at(1, 20, 0);  vif.mode_i = 2'd2;
    at(1, 20, 8);  chk_rgb("chk_still", 32'hFFF);

    // frame 2: gradient with modulo wrap
    at(2, 5, 10);  chk_rgb("grad_5", 32'h555);
    at(2, 5, 31);  chk_rgb("grad_15", 32'hFFF);
    at(2, 5, 32);  chk_rgb("grad_wrap", 32'h000);
    at(2, 5, 40);  chk_rgb("grad_4", 32'h444);
    at(2, 30, 0);  vif.mode_i = 2'd3;

    // frame 3: border, then a mid-frame reset
    at(3, 0, 0);   chk_rgb("brd_00", 32'hFFF);
    at(3, 0, 70);  chk_rgb("brd_blank", 32'h000);
    at(3, 1, 1);   chk_rgb("brd_11", 32'h000);
    at(3, 5, 63);  chk_rgb("brd_right", 32'hFFF);
    at(3, 20, 30); chk_rgb("brd_inner", 32'h000);
    at(3, 30, 10);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst1");
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst2");
    rst = 1'b0;
    pix = -1;
    last_fs = -1;
    step();
    check("rel_fs", 32'(vif.o_frame_start), 32'd1);
    check("rel_hc", 32'(vif.hcount_o), 32'd0);
    check("rel_vc", 32'(vif.vcount_o), 32'd0);
    chk_rgb("rel_rgb", 32'hFFF);
    step();
    check("rel_fs_low", 32'(vif.o_frame_start), 32'd0);
    check("rel_hc1", 32'(vif.hcount_o), 32'd1);
    at(0, 47, 5);  chk_rgb("brd_bottom", 32'hFFF);
    at(0, 47, 63); chk_rgb("brd_corner", 32'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
